// File: rtl/q_drain_if.sv
// q_drain_if: queue-side pop port and downstream valid/ready stream of q_drain.
// master = the drain block, slave = queue plus consumer side.
interface q_drain_if #(
  parameter int unsigned WORD_SZ = 32
);
  logic               q_empty;
  logic [WORD_SZ-1:0] q_data;
  logic               q_rd;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_SZ-1:0] out_data;
  logic               out_last;

  modport master (
    input  q_empty, q_data, out_ready,
    output q_rd, out_valid, out_data, out_last
  );

  modport slave (
    output q_empty, q_data, out_ready,
    input  q_rd, out_valid, out_data, out_last
  );
endinterface

// File: rtl/q_drain.sv
// q_drain: pops words from the circular word queue, absorbs its one-cycle read
// latency in a 2-entry skid buffer and presents a valid/ready stream with a
// burst-boundary marker every BURST_LEN beats.
// Optional feature macro: Q_DRAIN_STATS_EN adds the stat_words beat counter.
module q_drain #(
  parameter int unsigned WORD_SZ   = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  q_drain_if.master   bus
`ifdef Q_DRAIN_STATS_EN
  ,
  output logic [31:0] stat_words
`endif
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]         occ;
  logic               inflight;
  logic [CNT_W-1:0]   beat_cnt;
  logic [WORD_SZ-1:0] head_q;
  logic [WORD_SZ-1:0] tail_q;
  logic               out_valid_q;
  logic               out_last_q;

  logic               xfer;
  logic [2:0]         slots;
  logic               pop_ok;
  logic               q_rd_c;
  logic [1:0]         occ_nxt;
  logic [WORD_SZ-1:0] head_nxt;
  logic [WORD_SZ-1:0] tail_nxt;
  logic [CNT_W-1:0]   beat_nxt;

  // Credit check: pop only if buffer + in-flight word still fit after this cycle's transfer.
  always_comb begin
    xfer   = out_valid_q & bus.out_ready;
    slots  = 3'(occ) + 3'(inflight) - 3'(xfer);
    pop_ok = (slots < 3'd2);
    q_rd_c = rst & ~bus.q_empty & pop_ok;
  end

  // Skid buffer update: drop the head on transfer, then append the returning word at the tail.
  always_comb begin
    head_nxt = head_q;
    tail_nxt = tail_q;
    occ_nxt  = occ;
    if (xfer) begin
      head_nxt = tail_q;
      occ_nxt  = occ - 2'd1;
    end
    if (inflight) begin
      if (occ_nxt == 2'd0) begin
        head_nxt = bus.q_data;
      end else begin
        tail_nxt = bus.q_data;
      end
      occ_nxt = occ_nxt + 2'd1;
    end
  end

  // Beat counter advances only on accepted beats and wraps at the burst end.
  always_comb begin
    beat_nxt = beat_cnt;
    if (xfer) begin
      beat_nxt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // State and registered stream outputs; reset discards buffered and in-flight words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ         <= 2'd0;
      inflight    <= 1'b0;
      beat_cnt    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      occ         <= occ_nxt;
      inflight    <= q_rd_c;
      beat_cnt    <= beat_nxt;
      head_q      <= head_nxt;
      tail_q      <= tail_nxt;
      out_valid_q <= (occ_nxt != 2'd0);
      out_last_q  <= (beat_nxt == LAST_BEAT);
    end
  end

  assign bus.q_rd      = q_rd_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_q;
  assign bus.out_last  = out_last_q;

`ifdef Q_DRAIN_STATS_EN
  // Saturating count of accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_words <= 32'd0;
    end else if (xfer && (stat_words != 32'hFFFF_FFFF)) begin
      stat_words <= stat_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_q_drain.sv
// tb_q_drain: directed bench for q_drain with a small registered-read queue model.
module tb_q_drain;
  localparam int unsigned WORD_SZ   = 32;
  localparam int unsigned BURST_LEN = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  q_drain_if #(.WORD_SZ(WORD_SZ)) bus ();

`ifdef Q_DRAIN_STATS_EN
  logic [31:0] stat_words;
`endif

  q_drain #(
    .WORD_SZ  (WORD_SZ),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef Q_DRAIN_STATS_EN
    ,
    .stat_words(stat_words)
`endif
  );

  // Queue model: empty flag from pointers, data registered one cycle after a pop.
  logic [WORD_SZ-1:0] qmem [0:63];
  int unsigned        wr_ptr = 0;
  int unsigned        rd_ptr = 0;
  logic [WORD_SZ-1:0] q_data_r = '0;

  assign bus.q_empty = (rd_ptr == wr_ptr);
  assign bus.q_data  = q_data_r;

  always @(posedge clk) begin
    if (bus.q_rd) begin
      q_data_r <= qmem[rd_ptr % 64];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    qmem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Checks the beat on the stream now, then moves to the next sample point.
  task automatic expect_beat(input string tag, input logic [31:0] w, input logic last);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  bus.out_data, w);
    check({tag, "_last"},  32'(bus.out_last), 32'(last));
    @(negedge clk);
  endtask

  // A pop must never be issued against an empty queue.
  always @(negedge clk) begin
    if (rst === 1'b1) check("rd_while_empty", 32'(bus.q_rd & bus.q_empty), 32'd0);
  end

  initial begin
    rst           = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held with a non-empty queue: nothing popped, nothing presented.
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    repeat (2) begin
      @(negedge clk);
      check("rst_q_rd", 32'(bus.q_rd), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_last", 32'(bus.out_last), 32'd0);
    end

    // Release: pop immediately, first word presented two edges later, full rate.
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("first_q_rd", 32'(bus.q_rd), 32'd1);
    @(negedge clk);
    check("lat_valid_n1", 32'(bus.out_valid), 32'd0);
    check("lat_inflight", 32'(dut.inflight), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) expect_beat("burst", 32'h10 + 32'(i), (i % 4) == 3);
    check("burst_drained", 32'(bus.out_valid), 32'd0);

    // Stall with 3 words queued: buffer fills to 2, head held, pops stop.
    bus.out_ready = 1'b0;
    push(32'h20); push(32'h21); push(32'h22);
    repeat (5) @(negedge clk);
    check("stall_occ", 32'(dut.occ), 32'd2);
    check("stall_q_rd", 32'(bus.q_rd), 32'd0);
    check("stall_q_empty", 32'(bus.q_empty), 32'd0);
    bus.out_ready = 1'b1;
    expect_beat("stall", 32'h20, 1'b0);
    expect_beat("stall", 32'h21, 1'b0);
    expect_beat("stall", 32'h22, 1'b0);
    check("stall_drained", 32'(bus.out_valid), 32'd0);

    // Queue runs empty while the single word is in flight; it closes the burst.
    push(32'h30);
    #1;
    check("tail_q_rd", 32'(bus.q_rd), 32'd1);
    @(negedge clk);
    check("tail_inflight", 32'(dut.inflight), 32'd1);
    check("tail_q_rd_off", 32'(bus.q_rd), 32'd0);
    @(negedge clk);
    expect_beat("tail", 32'h30, 1'b1);
    check("tail_drained", 32'(bus.out_valid), 32'd0);
    check("tail_q_rd_end", 32'(bus.q_rd), 32'd0);

    // Reset mid-burst with beat_cnt=2 and a full buffer.
    push(32'h40); push(32'h41);
    @(negedge clk);
    @(negedge clk);
    expect_beat("mid", 32'h40, 1'b0);
    expect_beat("mid", 32'h41, 1'b0);
    bus.out_ready = 1'b0;
    push(32'h42); push(32'h43); push(32'h44);
    repeat (4) @(negedge clk);
    check("mid_occ", 32'(dut.occ), 32'd2);
    check("mid_beat", 32'(dut.beat_cnt), 32'd2);
    check("mid_head", bus.out_data, 32'h42);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", bus.out_data, 32'd0);
    check("arst_last", 32'(bus.out_last), 32'd0);
    check("arst_q_rd", 32'(bus.q_rd), 32'd0);
    @(negedge clk);
    check("arst_hold_q_rd", 32'(bus.q_rd), 32'd0);
    check("arst_occ", 32'(dut.occ), 32'd0);
    push(32'h45); push(32'h46); push(32'h47);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rel_q_rd", 32'(bus.q_rd), 32'd1);
    @(negedge clk);
    check("rel_valid_n1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    expect_beat("post", 32'h44, 1'b0);
    expect_beat("post", 32'h45, 1'b0);
    expect_beat("post", 32'h46, 1'b0);
    expect_beat("post", 32'h47, 1'b1);
    check("post_drained", 32'(bus.out_valid), 32'd0);

`ifdef Q_DRAIN_STATS_EN
    // Beat counter: exact count, then saturation near the top.
    rst = 1'b0;
    @(negedge clk);
    check("stat_rst", stat_words, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) push(32'h50 + 32'(i));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) expect_beat("stat", 32'h50 + 32'(i), (i % 4) == 3);
    check("stat_ten", stat_words, 32'd10);
    force dut.stat_words = 32'hFFFF_FFFE;
    #1;
    release dut.stat_words;
    push(32'h60); push(32'h61); push(32'h62);
    @(negedge clk);
    @(negedge clk);
    expect_beat("sat", 32'h60, 1'b0);
    expect_beat("sat", 32'h61, 1'b1);
    expect_beat("sat", 32'h62, 1'b0);
    check("stat_sat", stat_words, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
